// File: rtl/sensor_ascii_framer.sv
// Converts a tagged 16-bit sensor reading to fixed-width ASCII decimal with a
// serial double-dabble engine and streams the text frame over valid/ready.
module sensor_ascii_framer #(
    parameter logic [7:0] HUM_TAG  = 8'h48,
    parameter logic [7:0] TEMP_TAG = 8'h54,
    parameter logic [7:0] DIST_TAG = 8'h44,
    parameter logic [7:0] SEP_CHAR = 8'h20,
    parameter bit         EOL_CRLF = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        meas_valid,
    input  logic        meas_src,
    input  logic [15:0] meas_data,
    output logic        busy,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        frame_done,
    output logic        err_drop
);

    // state    | meaning
    // IDLE     | waiting for a measurement
    // CONV     | 16-cycle binary to BCD conversion
    // EMIT_TAG | presenting the field tag byte
    // EMIT_DIG | presenting decimal digits, MSD first
    // EMIT_SEP | presenting the separator between DHT11 fields
    // EMIT_EOL | presenting CR/LF
    typedef enum logic [2:0] {IDLE, CONV, EMIT_TAG, EMIT_DIG, EMIT_SEP, EMIT_EOL} state_t;

    state_t      state_q, state_d;
    logic        src_q, src_d;
    logic [7:0]  temp_q, temp_d;
    logic        field_q, field_d;
    logic [15:0] bin_q, bin_d;
    logic [19:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  dig_q, dig_d;
    logic        eol_q, eol_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        err_drop_q, err_drop_d;

    logic [19:0] bcd_corr;
    logic [3:0]  digit;
    logic [7:0]  tag_byte;
    logic [7:0]  cur_byte;
    logic        last_eol;

    function automatic logic [19:0] add3(input logic [19:0] b);
        logic [19:0] r;
        r = b;
        for (int i = 0; i < 5; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign bcd_corr = add3(bcd_q);
    assign tag_byte = src_q ? DIST_TAG : (field_q ? TEMP_TAG : HUM_TAG);
    assign last_eol = !EOL_CRLF || eol_q;

    always_comb begin
        case (dig_q)
            3'd0:    digit = bcd_q[3:0];
            3'd1:    digit = bcd_q[7:4];
            3'd2:    digit = bcd_q[11:8];
            3'd3:    digit = bcd_q[15:12];
            3'd4:    digit = bcd_q[19:16];
            default: digit = 4'd0;
        endcase
    end

    always_comb begin
        case (state_q)
            EMIT_TAG: cur_byte = tag_byte;
            EMIT_DIG: cur_byte = 8'h30 + {4'h0, digit};
            EMIT_SEP: cur_byte = SEP_CHAR;
            EMIT_EOL: cur_byte = (EOL_CRLF && !eol_q) ? 8'h0D : 8'h0A;
            default:  cur_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        temp_d     = temp_q;
        field_d    = field_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        dig_d      = dig_q;
        eol_d      = eol_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        err_drop_d = meas_valid && (state_q != IDLE);
        frame_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (meas_valid) begin
                    src_d   = meas_src;
                    temp_d  = meas_data[7:0];
                    field_d = 1'b0;
                    bin_d   = meas_src ? meas_data : {8'h00, meas_data[15:8]};
                    bcd_d   = 20'd0;
                    cnt_d   = 4'd15;
                    state_d = CONV;
                end
            end
            CONV: begin
                bcd_d = {bcd_corr[18:0], bin_q[15]};
                bin_d = {bin_q[14:0], 1'b0};
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    state_d = EMIT_TAG;
                end
            end
            default: begin
                // Each output byte is loaded once, then held until accepted.
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = cur_byte;
                end else if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    case (state_q)
                        EMIT_TAG: begin
                            state_d = EMIT_DIG;
                            dig_d   = src_q ? 3'd4 : 3'd2;
                            eol_d   = 1'b0;
                        end
                        EMIT_DIG: begin
                            if (dig_q == 3'd0) begin
                                state_d = (!src_q && !field_q) ? EMIT_SEP : EMIT_EOL;
                            end else begin
                                dig_d = dig_q - 3'd1;
                            end
                        end
                        EMIT_SEP: begin
                            field_d = 1'b1;
                            bin_d   = {8'h00, temp_q};
                            bcd_d   = 20'd0;
                            cnt_d   = 4'd15;
                            state_d = CONV;
                        end
                        EMIT_EOL: begin
                            if (last_eol) begin
                                frame_done = 1'b1;
                                state_d    = IDLE;
                            end else begin
                                eol_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            src_q      <= 1'b0;
            temp_q     <= 8'h00;
            field_q    <= 1'b0;
            bin_q      <= 16'h0000;
            bcd_q      <= 20'h00000;
            cnt_q      <= 4'd0;
            dig_q      <= 3'd0;
            eol_q      <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            err_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            temp_q     <= temp_d;
            field_q    <= field_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            dig_q      <= dig_d;
            eol_q      <= eol_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            err_drop_q <= err_drop_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign err_drop = err_drop_q;

endmodule

// File: tb/tb_sensor_ascii_framer.sv
// Scoreboard bench for sensor_ascii_framer: CRLF instance plus an LF-only instance.
module tb_sensor_ascii_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        meas_valid = 1'b0;
    logic        meas_src = 1'b0;
    logic [15:0] meas_data = 16'h0000;
    logic        busy;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        frame_done;
    logic        err_drop;

    logic        mv2 = 1'b0;
    logic        src2 = 1'b0;
    logic [15:0] data2 = 16'h0000;
    logic        busy2;
    logic [7:0]  tx_data2;
    logic        tx_valid2;
    logic        rdy2 = 1'b1;
    logic        frame_done2;
    logic        err_drop2;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int frames = 0;
    int errs = 0;
    int acc2 = 0;
    int frames2 = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random 30%, 2: held low

    logic [7:0] exp_q[$];
    logic [7:0] exp2[$];

    sensor_ascii_framer dut (
        .clk(clk), .rst(rst), .meas_valid(meas_valid), .meas_src(meas_src),
        .meas_data(meas_data), .busy(busy), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .frame_done(frame_done), .err_drop(err_drop)
    );

    sensor_ascii_framer #(.EOL_CRLF(1'b0)) dut_lf (
        .clk(clk), .rst(rst), .meas_valid(mv2), .meas_src(src2),
        .meas_data(data2), .busy(busy2), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(rdy2), .frame_done(frame_done2), .err_drop(err_drop2)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            1:       tx_ready = ($urandom_range(0, 99) < 30);
            2:       tx_ready = 1'b0;
            default: tx_ready = 1'b1;
        endcase
    end

    logic       pend = 1'b0;
    logic [7:0] pend_data = 8'h00;

    always @(negedge clk) begin
        logic [7:0] e;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                checks++;
                if (!tx_valid || tx_data !== pend_data) begin
                    errors++;
                    $display("FAIL hold_stable valid=%b data=%h required valid=1 data=%h",
                             tx_valid, tx_data, pend_data);
                end
            end
            pend = tx_valid && !tx_ready;
            pend_data = tx_data;
            if (tx_valid && tx_ready) begin
                acc_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte got=%h required=none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        errors++;
                        $display("FAIL byte got=%h required=%h", tx_data, e);
                    end
                end
            end
            if (frame_done) begin
                frames++;
                checks++;
                if (!(tx_valid && tx_ready) || tx_data !== 8'h0A) begin
                    errors++;
                    $display("FAIL frame_done_align valid=%b ready=%b data=%h required 1 1 0a",
                             tx_valid, tx_ready, tx_data);
                end
            end
            if (err_drop) errs++;
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst) begin
            if (tx_valid2 && rdy2) begin
                acc2++;
                checks++;
                if (exp2.size() == 0) begin
                    errors++;
                    $display("FAIL lf_unexpected_byte got=%h required=none", tx_data2);
                end else begin
                    e = exp2.pop_front();
                    if (tx_data2 !== e) begin
                        errors++;
                        $display("FAIL lf_byte got=%h required=%h", tx_data2, e);
                    end
                end
            end
            if (frame_done2) begin
                frames2++;
                checks++;
                if (tx_data2 !== 8'h0A || exp2.size() != 0) begin
                    errors++;
                    $display("FAIL lf_frame_done data=%h left=%0d required 0a 0", tx_data2, exp2.size());
                end
            end
        end
    end

    task automatic send(input logic s, input logic [15:0] d);
        @(posedge clk);
        #1;
        meas_valid = 1'b1;
        meas_src = s;
        meas_data = d;
        @(posedge clk);
        #1;
        meas_valid = 1'b0;
    endtask

    task automatic push_num(input int v, input int ndig);
        int p;
        p = 1;
        repeat (ndig - 1) p = p * 10;
        repeat (ndig) begin
            exp_q.push_back(8'h30 + 8'((v / p) % 10));
            p = p / 10;
        end
    endtask

    task automatic push_dist(input int d);
        exp_q.push_back(8'h44);
        push_num(d, 5);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic push_dht(input int h, input int t);
        exp_q.push_back(8'h48);
        push_num(h, 3);
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h54);
        push_num(t, 3);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic wait_frames(input int target, input string name);
        int t;
        t = 0;
        while (frames < target && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
        checks++;
        if (frames < target || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s frames=%0d left=%0d required frames=%0d left=0",
                     name, frames, exp_q.size(), target);
        end
    endtask

    task automatic wait_acc(input int target, input string name);
        int t;
        t = 0;
        while (acc_cnt < target && t < 3000) begin
            @(negedge clk);
            #1;
            t++;
        end
        checks++;
        if (acc_cnt < target) begin
            errors++;
            $display("FAIL %s accepted=%0d required=%0d", name, acc_cnt, target);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 8'h00 ||
            frame_done !== 1'b0 || err_drop !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b valid=%b data=%h done=%b drop=%b required 0 0 00 0 0",
                     busy, tx_valid, tx_data, frame_done, err_drop);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_dht11();
        int f0;
        f0 = frames;
        push_dht(45, 23);
        send(1'b0, 16'h2D17);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL dht_busy got=%b required=1", busy);
        end
        wait_frames(f0 + 1, "dht_frame");
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || frames != f0 + 1) begin
            errors++;
            $display("FAIL dht_after busy=%b frames=%0d required busy=0 frames=%0d", busy, frames, f0 + 1);
        end
    endtask

    task automatic test_hcsr04_bounds();
        int lat;
        logic [15:0] vals[2];
        vals[0] = 16'hFFFF;
        vals[1] = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            push_dist(int'(vals[i]));
            send(1'b1, vals[i]);
            lat = 0;
            do begin
                @(posedge clk);
                #1;
                lat++;
            end while (!tx_valid && lat < 40);
            checks++;
            if (lat != 17) begin
                errors++;
                $display("FAIL first_valid_latency got=%0d required=17", lat);
            end
            wait_frames(frames + 1, "dist_frame");
        end
    endtask

    task automatic test_backpressure();
        int base;
        int f0;
        base = acc_cnt;
        f0 = frames;
        push_dht(45, 23);
        rdy_mode = 1;
        send(1'b0, 16'h2D17);
        wait_acc(base + 2, "bp_pre_hold");
        rdy_mode = 2;
        repeat (40) @(posedge clk);
        rdy_mode = 1;
        wait_frames(f0 + 1, "bp_frame");
        rdy_mode = 0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_overlap();
        int base;
        int f0;
        int e0;
        logic seen;
        base = acc_cnt;
        f0 = frames;
        e0 = errs;
        push_dist(4321);
        send(1'b1, 16'd4321);
        repeat (3) @(posedge clk);
        send(1'b0, 16'h1111);
        wait_acc(base + 6, "ov_digits");
        rdy_mode = 2;
        repeat (3) @(posedge clk);
        send(1'b1, 16'h2222);
        repeat (2) @(posedge clk);
        rdy_mode = 0;
        wait_frames(f0 + 1, "ov_frame");
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (tx_valid || busy) seen = 1'b1;
        end
        checks++;
        if (seen || frames != f0 + 1 || errs != e0 + 2) begin
            errors++;
            $display("FAIL overlap activity=%b frames=%0d drops=%0d required 0 %0d %0d",
                     seen, frames, errs - e0, f0 + 1, 2);
        end
    endtask

    task automatic test_reset_midframe();
        int base;
        int f0;
        base = acc_cnt;
        f0 = frames;
        push_dist(777);
        send(1'b1, 16'd777);
        wait_acc(base + 3, "rst_pre");
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid valid=%b busy=%b required 0 0", tx_valid, busy);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_dist(1234);
        send(1'b1, 16'd1234);
        wait_frames(f0 + 1, "post_reset_frame");
    endtask

    task automatic test_lf_only();
        int t;
        int a0;
        a0 = acc2;
        exp2.push_back(8'h48);
        exp2.push_back(8'h31);
        exp2.push_back(8'h30);
        exp2.push_back(8'h30);
        exp2.push_back(8'h20);
        exp2.push_back(8'h54);
        exp2.push_back(8'h30);
        exp2.push_back(8'h30);
        exp2.push_back(8'h30);
        exp2.push_back(8'h0A);
        @(posedge clk);
        #1;
        mv2 = 1'b1;
        src2 = 1'b0;
        data2 = 16'h6400;
        @(posedge clk);
        #1;
        mv2 = 1'b0;
        t = 0;
        while (frames2 < 1 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
        checks++;
        if (frames2 != 1 || acc2 - a0 != 10 || exp2.size() != 0) begin
            errors++;
            $display("FAIL lf_frame frames=%0d bytes=%0d left=%0d required 1 10 0",
                     frames2, acc2 - a0, exp2.size());
        end
    endtask

    initial begin
        test_reset();
        test_dht11();
        test_hcsr04_bounds();
        test_backpressure();
        test_overlap();
        test_reset_midframe();
        test_lf_only();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
